// File: rtl/aes_pkg.sv
// Shared AES-128 types and constant tables for the key schedule and the round datapath.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } ks_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

endpackage

// File: rtl/aes_subword.sv
// SubWord: four forward S-box lookups on a 32-bit word, purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  word_t word_in,
    output word_t word_out
);

    assign word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                       SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};

endmodule

// File: rtl/aes128_key_sched_iter.sv
// Iterative AES-128 key schedule: streams round keys 0..10 (mode 0) or 10..0 (mode 1),
// one per rk_valid/rk_ready handshake, recomputing each key from the previous one.
//
// state | meaning
// IDLE  | waiting for start; key register holds last schedule's final key
// EMIT  | rk_valid high, advancing the key register on each handshake
// FIN   | one-cycle done pulse; a start seen here launches the next schedule
module aes128_key_sched_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         done
);

    if (NR != 10) begin : g_nr_check
        $error("aes128_key_sched_iter supports only NR = 10");
    end

    ks_state_e   state_q, state_d;
    key_t        key_q, key_d;
    logic        mode_q, mode_d;
    logic [3:0]  idx_q, idx_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        done_q, done_d;

    word_t w0, w1, w2, w3;
    word_t rev_w3, sw_src, sw_in, sw_out, tmp;
    word_t f0, f1, f2, f3;
    logic [3:0] rc_idx;
    logic [7:0] rc;
    key_t  key_next;

    assign {w0, w1, w2, w3} = key_q;

    // Reverse step needs the recovered w3 before the S-box, so one SubWord serves both directions.
    assign rev_w3 = w3 ^ w2;
    assign sw_src = mode_q ? rev_w3 : w3;
    assign sw_in  = {sw_src[23:0], sw_src[31:24]};

    aes_subword u_subword (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    always_comb begin
        rc_idx = mode_q ? idx_q : (idx_q + 4'd1);
        rc     = 8'h00;
        if (rc_idx >= 4'd1 && rc_idx <= 4'd10) begin
            rc = RCON[rc_idx];
        end
    end

    assign tmp = sw_out ^ {rc, 24'h0};
    assign f0  = w0 ^ tmp;
    assign f1  = w1 ^ f0;
    assign f2  = w2 ^ f1;
    assign f3  = w3 ^ f2;

    assign key_next = mode_q ? {w0 ^ tmp, w1 ^ w0, w2 ^ w1, rev_w3}
                             : {f0, f1, f2, f3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (start) begin
                    key_d   = key_in;
                    mode_d  = mode;
                    idx_d   = mode ? 4'(NR) : 4'd0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        key_d = key_next;
                        idx_d = mode_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d == ST_EMIT);
        valid_d = (state_d == ST_EMIT);
        done_d  = (state_d == ST_FIN);
        last_d  = (state_d == ST_EMIT) && (mode_d ? (idx_d == 4'd0) : (idx_d == 4'(NR)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = valid_q;
    assign rk_data  = key_q;
    assign rk_index = idx_q;
    assign rk_last  = last_q;
    assign done     = done_q;

endmodule
